// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multi-port register file.
//    clr_state_e : clear-engine states
//    XLEN_DEF    : default register width
//    NREGS_DEF   : default register count
//    ZERO_REG    : index of the hardwired-zero register
package regfile_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;
   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;
   localparam int ZERO_REG  = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits for hazard detection.
//    clk_i, rst_ni : clock, async active-low reset
//    clr_all_i     : zero every busy bit (clear engine start, highest priority)
//    set_en_i/set_addr_i : accepted reservation, marks a register busy
//    clr_en_i/clr_addr_i : accepted writes, one per write port, clear busy
//    rd_addr_i/rd_busy_o : NRD lookups of the registered busy bits
module regfile_scoreboard #(
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS),
   parameter int NRD   = 2,
   parameter int NWR   = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_all_i,
   input  logic              set_en_i,
   input  logic [AW-1:0]     set_addr_i,
   input  logic [NWR-1:0]    clr_en_i,
   input  logic [NWR*AW-1:0] clr_addr_i,
   input  logic [NRD*AW-1:0] rd_addr_i,
   output logic [NRD-1:0]    rd_busy_o
);
   logic [NREGS-1:0] busy_q, busy_d;

   // reserve is applied after the write clears so it wins on the same register
   always_comb begin
      busy_d = busy_q;
      for (int p = 0; p < NWR; p++)
         if (clr_en_i[p]) busy_d[clr_addr_i[p*AW +: AW]] = 1'b0;
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
      if (clr_all_i) busy_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) busy_q <= '0;
      else busy_q <= busy_d;

   always_comb begin
      rd_busy_o = '0;
      for (int k = 0; k < NRD; k++) rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with bypass, hazard scoreboard and clear engine.
//    clk_i, rst_ni          : clock, async active-low reset
//    rd_addr_i/rd_data_o    : NRD combinational read ports (with write bypass)
//    rd_busy_o              : pending-write bit of each read address
//    wr_en_i/wr_addr_i/wr_data_i : NWR write ports, higher index wins
//    wr_ready_o             : writes and reservations accepted (low during clear)
//    rsv_en_i/rsv_addr_i    : reserve a destination register
//    clr_req_i/clr_busy_o/clr_done_o : sequential array clear
//    dbg_addr_i/dbg_data_o  : raw array tap, no bypass
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS),
   parameter int NRD   = 2,
   parameter int NWR   = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NRD*AW-1:0]   rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_data_o,
   output logic [NRD-1:0]      rd_busy_o,
   input  logic [NWR-1:0]      wr_en_i,
   input  logic [NWR*AW-1:0]   wr_addr_i,
   input  logic [NWR*XLEN-1:0] wr_data_i,
   output logic                wr_ready_o,
   input  logic                rsv_en_i,
   input  logic [AW-1:0]       rsv_addr_i,
   input  logic                clr_req_i,
   output logic                clr_busy_o,
   output logic                clr_done_o,
   input  logic [AW-1:0]       dbg_addr_i,
   output logic [XLEN-1:0]     dbg_data_o
);
   logic [XLEN-1:0] regs_q [NREGS];
   clr_state_e      state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [NWR-1:0]  wr_acc;
   logic            rsv_acc, clr_start;
   logic [NRD-1:0]  sb_busy;

   assign wr_ready_o = state_q == IDLE;
   assign clr_busy_o = state_q != IDLE;
   assign clr_done_o = state_q == DONE;
   assign clr_start  = wr_ready_o && clr_req_i;
   assign rsv_acc    = rsv_en_i && wr_ready_o && rsv_addr_i != AW'(ZERO_REG);

   always_comb begin
      wr_acc = '0;
      for (int p = 0; p < NWR; p++)
         wr_acc[p] = wr_en_i[p] && wr_ready_o && wr_addr_i[p*AW +: AW] != AW'(ZERO_REG);
   end

   always_comb begin
      state_d = clr_start ? CLEAR :
                (state_q == CLEAR && ptr_q == AW'(NREGS - 1)) ? DONE :
                state_q == DONE ? IDLE : state_q;
      ptr_d   = state_q == CLEAR ? ptr_q + AW'(1) : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end

   // wr_acc is only ever set in IDLE, so clearing and writing never collide
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (state_q == CLEAR) begin
         regs_q[ptr_q] <= '0;
      end else begin
         for (int p = 0; p < NWR; p++)
            if (wr_acc[p]) regs_q[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*XLEN +: XLEN];
      end

   // later ports override earlier ones, giving the highest-index bypass priority
   always_comb begin
      rd_data_o = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
         for (int p = 0; p < NWR; p++)
            if (wr_acc[p] && wr_addr_i[p*AW +: AW] == rd_addr_i[k*AW +: AW])
               rd_data_o[k*XLEN +: XLEN] = wr_data_i[p*XLEN +: XLEN];
         if (!rst_ni || rd_addr_i[k*AW +: AW] == AW'(ZERO_REG)) rd_data_o[k*XLEN +: XLEN] = '0;
      end
   end

   assign rd_busy_o  = rst_ni ? sb_busy : '0;
   assign dbg_data_o = rst_ni ? regs_q[dbg_addr_i] : '0;

   regfile_scoreboard #(.NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR)) u_sb (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_all_i  (clr_start),
      .set_en_i   (rsv_acc),
      .set_addr_i (rsv_addr_i),
      .clr_en_i   (wr_acc),
      .clr_addr_i (wr_addr_i),
      .rd_addr_i  (rd_addr_i),
      .rd_busy_o  (sb_busy)
   );
endmodule
